// File: rtl/booth4_pkg.sv
// Shared types and constants for the radix-4 Booth multiply controller:
// FSM states, ALU function codes, register op codes and the control word
// that the FSM drives onto the datapath.
package booth4_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // ALU function select
  localparam logic [3:0] FN_ADD  = 4'd0;  // X + Y
  localparam logic [3:0] FN_SUB  = 4'd1;  // X - Y
  localparam logic [3:0] FN_ADD2 = 4'd2;  // X + 2Y
  localparam logic [3:0] FN_SUB2 = 4'd3;  // X - 2Y

  // Register operation select
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC1 = 3'b001;
  localparam logic [2:0] OP_INC2 = 3'b010;
  localparam logic [2:0] OP_DEC1 = 3'b011;
  localparam logic [2:0] OP_DEC2 = 3'b100;
  localparam logic [2:0] OP_SHR2 = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;

  // Complete control word presented to the datapath in one cycle
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ld_p;
    logic       ld_mcand;
    logic       ld_mplier;
    logic       ld_count;
    logic       p_clr;
    logic [2:0] sel_p;
    logic [2:0] sel_mplier;
    logic [2:0] sel_count;
    logic [3:0] func_sel;
    logic       tr_p;
    logic       tr_mcand;
    logic       tr_mplier;
    logic       tr_count;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Control word for a given state. fn is only used by ADD, where it
  // carries the ALU operation chosen by the recoder in the preceding EVAL.
  // Only P and Mcand ever drive the buses, and they sit on different buses.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] fn);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      IDLE: begin
        c = CTRL_IDLE;
      end
      LOAD: begin
        c.busy       = 1'b1;
        c.ld_mcand   = 1'b1;
        c.ld_mplier  = 1'b1;
        c.ld_count   = 1'b1;
        c.p_clr      = 1'b1;
        c.sel_p      = OP_HOLD;
        c.sel_mplier = OP_HOLD;
        c.sel_count  = OP_HOLD;
      end
      EVAL: begin
        c.busy = 1'b1;
      end
      ADD: begin
        c.busy     = 1'b1;
        c.tr_p     = 1'b1;
        c.tr_mcand = 1'b1;
        c.ld_p     = 1'b1;
        c.sel_p    = OP_HOLD;
        c.func_sel = fn;
      end
      SHIFT: begin
        c.busy       = 1'b1;
        c.ld_p       = 1'b1;
        c.sel_p      = OP_SHR2;
        c.ld_mplier  = 1'b1;
        c.sel_mplier = OP_SHR2;
        c.ld_count   = 1'b1;
        c.sel_count  = OP_DEC1;
      end
      DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: begin
        c = CTRL_IDLE;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth4_recode.sv
// Radix-4 Booth recoder: turns the 3-bit window {Mplier[1], Mplier[0], q_-1}
// into "an ALU pass is needed" plus the ALU function for that pass.
// Digits: 0 -> skip, +1 -> X+Y, -1 -> X-Y, +2 -> X+2Y, -2 -> X-2Y.
module booth4_recode
  import booth4_pkg::*;
(
  input  logic [2:0] win,
  output logic       need_add,
  output logic [3:0] func_sel
);

  // Map each Booth window to its ALU operation
  always_comb begin
    need_add = 1'b0;
    func_sel = FN_ADD;
    case (win)
      3'b000, 3'b111: begin
        need_add = 1'b0;
        func_sel = FN_ADD;
      end
      3'b001, 3'b010: begin
        need_add = 1'b1;
        func_sel = FN_ADD;
      end
      3'b011: begin
        need_add = 1'b1;
        func_sel = FN_ADD2;
      end
      3'b100: begin
        need_add = 1'b1;
        func_sel = FN_SUB2;
      end
      3'b101, 3'b110: begin
        need_add = 1'b1;
        func_sel = FN_SUB;
      end
      default: begin
        need_add = 1'b0;
        func_sel = FN_ADD;
      end
    endcase
  end

endmodule

// File: rtl/booth4_mult_ctrl.sv
// Moore FSM sequencing the radix-4 Booth multiply datapath.
// IDLE -> LOAD -> (EVAL -> [ADD] -> SHIFT)* -> EVAL -> DONE -> IDLE.
// The whole control word is registered together with the state, so every
// output is the decode of the current state; the ALU function used in ADD
// is captured in that word while the FSM leaves EVAL.
// Optional macro BOOTH4_EARLY_TERM_EN: EVAL also finishes as soon as the
// datapath reports that the remaining multiplier bits are all zero.
module booth4_mult_ctrl
  import booth4_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_INIT = WIDTH / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] booth_win,
  input  logic       count_zero,
  input  logic       mplier_rest_zero,
  output logic       busy,
  output logic       done,
  output logic       ldP,
  output logic       ldMcand,
  output logic       ldMplier,
  output logic       ldCount,
  output logic       p_clr,
  output logic [2:0] selP,
  output logic [2:0] selMplier,
  output logic [2:0] selCount,
  output logic [3:0] func_sel,
  output logic       trP,
  output logic       trMcand,
  output logic       trMplier,
  output logic       trCount,
  output logic [7:0] cnt_init
);

  state_t     state;
  state_t     next_state;
  ctrl_t      ctrl_q;
  logic       need_add;
  logic [3:0] rec_func;
  logic       finish;

  booth4_recode u_recode (
    .win      (booth_win),
    .need_add (need_add),
    .func_sel (rec_func)
  );

`ifdef BOOTH4_EARLY_TERM_EN
  // Stop when Count expires or when only skip windows remain
  always_comb begin
    finish = count_zero | mplier_rest_zero;
  end
`else
  logic unused_rest_zero;
  assign unused_rest_zero = mplier_rest_zero;

  // Latency is fixed by Count alone
  always_comb begin
    finish = count_zero;
  end
`endif

  // Next-state selection; status inputs matter only in IDLE and EVAL
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD:  next_state = EVAL;
      EVAL: begin
        if (finish) begin
          next_state = DONE;
        end else if (need_add) begin
          next_state = ADD;
        end else begin
          next_state = SHIFT;
        end
      end
      ADD:   next_state = SHIFT;
      SHIFT: next_state = EVAL;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered control word; reset clears both at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ctrl_q <= CTRL_IDLE;
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state, rec_func);
    end
  end

  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign ldP       = ctrl_q.ld_p;
  assign ldMcand   = ctrl_q.ld_mcand;
  assign ldMplier  = ctrl_q.ld_mplier;
  assign ldCount   = ctrl_q.ld_count;
  assign p_clr     = ctrl_q.p_clr;
  assign selP      = ctrl_q.sel_p;
  assign selMplier = ctrl_q.sel_mplier;
  assign selCount  = ctrl_q.sel_count;
  assign func_sel  = ctrl_q.func_sel;
  assign trP       = ctrl_q.tr_p;
  assign trMcand   = ctrl_q.tr_mcand;
  assign trMplier  = ctrl_q.tr_mplier;
  assign trCount   = ctrl_q.tr_count;
  assign cnt_init  = 8'(CNT_INIT);

endmodule

// File: tb/tb_booth4_mult_ctrl.sv
// Self-checking bench for booth4_mult_ctrl. A small behavioural datapath
// (Count register, Booth window source, signed accumulator for P) reacts to
// the controller's strobes; expected latency, ALU sequence and product are
// computed from the Booth digit arithmetic.
module tb_booth4_mult_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] booth_win;
  logic       count_zero;
  logic       mplier_rest_zero;
  logic       busy, done, ldP, ldMcand, ldMplier, ldCount, p_clr;
  logic [2:0] selP, selMplier, selCount;
  logic [3:0] func_sel;
  logic       trP, trMcand, trMplier, trCount;
  logic [7:0] cnt_init;
  logic [23:0] outs;

  logic [2:0] rc_win;
  logic       rc_need;
  logic [3:0] rc_func;

  int n_checks = 0;
  int n_pass   = 0;

  // results of the last run_mult
  int  r_done_cyc, r_loads, r_adds, r_shifts, r_acc;
  bit  r_ctrl_err, r_after_idle;
  int  r_funcs[$];

  booth4_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .booth_win(booth_win),
    .count_zero(count_zero), .mplier_rest_zero(mplier_rest_zero),
    .busy(busy), .done(done), .ldP(ldP), .ldMcand(ldMcand),
    .ldMplier(ldMplier), .ldCount(ldCount), .p_clr(p_clr),
    .selP(selP), .selMplier(selMplier), .selCount(selCount),
    .func_sel(func_sel), .trP(trP), .trMcand(trMcand),
    .trMplier(trMplier), .trCount(trCount), .cnt_init(cnt_init)
  );

  booth4_recode u_rec (.win(rc_win), .need_add(rc_need), .func_sel(rc_func));

  assign outs = {busy, done, ldP, ldMcand, ldMplier, ldCount, p_clr,
                 selP, selMplier, selCount, func_sel,
                 trP, trMcand, trMplier, trCount};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Booth digit value of a window: m1 + m0 - 2*m2 (m0 here is q_-1 position)
  function automatic int digit(input logic [2:0] w);
    int b2, b1, b0;
    b2 = int'(w[2]); b1 = int'(w[1]); b0 = int'(w[0]);
    return b1 + b0 - 2 * b2;
  endfunction

  // ALU code that realises P + digit*Mcand
  function automatic int func_for(input int d);
    case (d)
      1:  return 0;
      -1: return 1;
      2:  return 2;
      -2: return 3;
      default: return -1;
    endcase
  endfunction

  // Run one multiply from an IDLE cycle with start raised; cycle 0 is that
  // IDLE cycle, cycle k is the state after clock edge k-1.
  task automatic run_mult(input logic [2:0] w0, input logic [2:0] w1,
                          input logic [2:0] w2, input logic [2:0] w3,
                          input int mcand, input int rest_eval, input bit hold);
    logic [2:0] win [4];
    int cnt, shifts, evals, d;
    bit fin, is_eval;
    win = '{w0, w1, w2, w3};
    r_funcs.delete();
    r_done_cyc = -1; r_loads = 0; r_adds = 0; r_shifts = 0; r_acc = 0;
    r_ctrl_err = 1'b0;
    cnt = 99; shifts = 0; evals = 0; fin = 1'b0;
    booth_win = 3'b000; count_zero = 1'b0; mplier_rest_zero = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    for (int c = 1; c <= 30 && !fin; c++) begin
      is_eval = busy && !done && !ldP && !ldMcand && !trP;
      booth_win  = (shifts < 4) ? win[shifts] : 3'b000;
      count_zero = (cnt == 0);
      mplier_rest_zero = is_eval && (rest_eval != 0) && (evals + 1 == rest_eval);
      if (is_eval) evals++;
      if (trMplier || trCount || (trP !== trMcand)) r_ctrl_err = 1'b1;
      if (ldMcand) begin
        r_loads++;
        if (!(ldMplier && ldCount && p_clr && !ldP && selP == 3'b000 &&
              selMplier == 3'b000 && selCount == 3'b000)) r_ctrl_err = 1'b1;
        cnt = int'(cnt_init); shifts = 0; r_acc = 0;
      end
      if (trP) begin
        r_adds++;
        r_funcs.push_back(int'(func_sel));
        if (!(ldP && selP == 3'b000)) r_ctrl_err = 1'b1;
        case (func_sel)
          4'd0: d = 1;
          4'd1: d = -1;
          4'd2: d = 2;
          4'd3: d = -2;
          default: begin d = 0; r_ctrl_err = 1'b1; end
        endcase
        r_acc += d * mcand * (1 << (2 * shifts));
      end
      if (ldP && selP == 3'b101) begin
        if (ldMplier && selMplier == 3'b101 && ldCount && selCount == 3'b011) begin
          r_shifts++;
        end else begin
          r_ctrl_err = 1'b1;
        end
        cnt--; shifts++;
      end
      if (done) begin
        r_done_cyc = c;
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    mplier_rest_zero = 1'b0;
    r_after_idle = (outs == 24'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; booth_win = 3'b000;
    count_zero = 1'b0; mplier_rest_zero = 1'b0;
    #2;
    n_checks++;
    if (outs !== 24'd0) $display("FAIL reset_outs: got %h expected 000000", outs);
    else n_pass++;
    n_checks++;
    if (cnt_init !== 8'd4) $display("FAIL cnt_init: got %0d expected 4", cnt_init);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (outs !== 24'd0) $display("FAIL idle_outs: got %h expected 000000", outs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_add();
    start = 1'b1;
    @(posedge clk); #1;              // LOAD
    start = 1'b0; booth_win = 3'b001; count_zero = 1'b0;
    @(posedge clk); #1;              // EVAL
    @(posedge clk); #1;              // ADD
    n_checks++;
    if (trP !== 1'b1 || busy !== 1'b1) $display("FAIL in_add: got trP=%b busy=%b expected 1 1", trP, busy);
    else n_pass++;
    rst = 1'b1; #1;
    n_checks++;
    if (outs !== 24'd0) $display("FAIL rst_mid_add: got %h expected 000000", outs);
    else n_pass++;
    @(negedge clk); rst = 1'b0; booth_win = 3'b000;
    @(posedge clk); #1;
    n_checks++;
    if (outs !== 24'd0) $display("FAIL post_rst_idle: got %h expected 000000", outs);
    else n_pass++;
    run_mult(3'b000, 3'b000, 3'b000, 3'b000, 5, 0, 1'b0);
    n_checks++;
    if (r_done_cyc != 11) $display("FAIL post_rst_start: done cycle %0d expected 11", r_done_cyc);
    else n_pass++;
  endtask

  task automatic test_all_skip();
    run_mult(3'b000, 3'b000, 3'b000, 3'b000, 7, 0, 1'b0);
    n_checks++;
    if (r_done_cyc != 11) $display("FAIL skip_done: cycle %0d expected 11", r_done_cyc);
    else n_pass++;
    n_checks++;
    if (r_shifts != 4 || r_adds != 0) $display("FAIL skip_counts: shifts=%0d adds=%0d expected 4 0", r_shifts, r_adds);
    else n_pass++;
    n_checks++;
    if (r_ctrl_err || !r_after_idle) $display("FAIL skip_ctrl: err=%0d idle_after=%0d expected 0 1", r_ctrl_err, r_after_idle);
    else n_pass++;
  endtask

  // Windows applied directly; expectations from the digit rule
  task automatic check_windows(input string name, input logic [2:0] w0, input logic [2:0] w1,
                               input logic [2:0] w2, input logic [2:0] w3, input int mcand);
    logic [2:0] w [4];
    int exp_adds, exp_acc;
    int exp_f[$];
    bit ok;
    w = '{w0, w1, w2, w3};
    exp_adds = 0; exp_acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (digit(w[i]) != 0) begin
        exp_adds++;
        exp_f.push_back(func_for(digit(w[i])));
      end
      exp_acc += digit(w[i]) * mcand * (1 << (2 * i));
    end
    run_mult(w0, w1, w2, w3, mcand, 0, 1'b0);
    n_checks++;
    if (r_done_cyc != 11 + exp_adds) $display("FAIL %s_done: cycle %0d expected %0d", name, r_done_cyc, 11 + exp_adds);
    else n_pass++;
    ok = (r_funcs.size() == exp_f.size());
    for (int i = 0; ok && i < exp_f.size(); i++) if (r_funcs[i] != exp_f[i]) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL %s_funcs: got %p expected %p", name, r_funcs, exp_f);
    else n_pass++;
    n_checks++;
    if (r_acc != exp_acc || r_ctrl_err) $display("FAIL %s_acc: got %0d err=%0d expected %0d err=0", name, r_acc, r_ctrl_err, exp_acc);
    else n_pass++;
  endtask

  task automatic test_recode_exhaustive();
    for (int i = 0; i < 8; i++) begin
      rc_win = 3'(i);
      #1;
      n_checks++;
      if (rc_need !== (digit(rc_win) != 0) ||
          (rc_need && int'(rc_func) != func_for(digit(rc_win))))
        $display("FAIL recode_%0d: got need=%b func=%0d expected need=%0d func=%0d",
                 i, rc_need, rc_func, digit(rc_win) != 0, func_for(digit(rc_win)));
      else n_pass++;
    end
  endtask

  // Random operands, windows derived from the multiplier bits; P must equal
  // the signed product and latency must follow the number of ALU passes
  task automatic test_random();
    logic [7:0] m;
    logic [8:0] ext;
    logic [2:0] w [4];
    int mc, adds, bad;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      m = 8'($urandom_range(0, 255));
      mc = int'($signed(8'($urandom_range(0, 255))));
      ext = {m, 1'b0};
      adds = 0;
      for (int i = 0; i < 4; i++) begin
        w[i] = ext[2*i +: 3];
        if (digit(w[i]) != 0) adds++;
      end
      run_mult(w[0], w[1], w[2], w[3], mc, 0, 1'b0);
      n_checks++;
      if (r_acc != mc * int'($signed(m)) || r_done_cyc != 11 + adds || r_ctrl_err || !r_after_idle) begin
        $display("FAIL rand_%0d: P=%0d cyc=%0d err=%0d idle=%0d expected P=%0d cyc=%0d",
                 k, r_acc, r_done_cyc, r_ctrl_err, r_after_idle, mc * int'($signed(m)), 11 + adds);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_start_handling();
    run_mult(3'b010, 3'b000, 3'b101, 3'b000, 3, 0, 1'b1);
    n_checks++;
    if (r_loads != 1) $display("FAIL start_held_loads: got %0d expected 1", r_loads);
    else n_pass++;
    n_checks++;
    if (!r_after_idle) $display("FAIL start_in_done: got outs=%h expected 000000", outs);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (ldMcand !== 1'b1 || busy !== 1'b1) $display("FAIL start_next_idle: got ldMcand=%b expected 1", ldMcand);
    else n_pass++;
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_early_term();
    int exp_cyc;
`ifdef BOOTH4_EARLY_TERM_EN
    exp_cyc = 5;
`else
    exp_cyc = 11;
`endif
    run_mult(3'b000, 3'b000, 3'b000, 3'b000, 9, 2, 1'b0);
    n_checks++;
    if (r_done_cyc != exp_cyc || !r_after_idle) $display("FAIL early_term: cycle %0d expected %0d", r_done_cyc, exp_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_all_skip();
    check_windows("full_recode", 3'b001, 3'b011, 3'b100, 3'b110, 13);
    check_windows("recode_tab", 3'b000, 3'b010, 3'b101, 3'b111, -21);
    test_recode_exhaustive();
    test_reset_mid_add();
    test_start_handling();
    test_early_term();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth4_mult_ctrl.md
Name: booth4_mult_ctrl

Overview:
Moore FSM that sequences the radix-4 Booth multiply datapath: the 17-bit product register P, the 8-bit Mcand, Mplier and Count registers, the tristate X/Y buses and the ALU.
- Drives every load strobe, register-op select, tristate enable and ALU function select.
- Consumes the datapath status lines: Booth window, count_zero, mplier_rest_zero.
- One multiply runs per start; done pulses when P holds the product.

Parameters:
WIDTH, 8, multiplier operand width; must be even; iterations = WIDTH/2
CNT_INIT, WIDTH/2, value the datapath loads into Count during LOAD (driven on cnt_init)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a multiply; sampled only in IDLE
booth_win  in  3  {Mplier[1], Mplier[0], q_-1} from the datapath
count_zero  in  1  registered Count == 0
mplier_rest_zero  in  1  remaining Mplier bits and q_-1 all zero (used only with EARLY_TERM_EN)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
ldP, ldMcand, ldMplier, ldCount  out  1 each  register load strobes
p_clr  out  1  synchronous clear of P (LOAD only)
selP, selMplier, selCount  out  3 each  register op: 000 hold, 001 +1, 010 +2, 011 -1, 100 -2, 101 >>2, 110 <<1
func_sel  out  4  ALU op: 0 X+Y, 1 X-Y, 2 X+2Y, 3 X-2Y
trP, trMcand, trMplier, trCount  out  1 each  tristate bus enables
cnt_init  out  8  CNT_INIT constant

Behaviour:
- Reset: state=IDLE. All strobes, enables, busy and done = 0. sel* = 000. func_sel = 0. Reset takes effect immediately, including mid-operation; no partial control word survives.
- Outputs are a decode of the state register; func_sel comes from a register captured in EVAL.
- IDLE: if start=1, go to LOAD. All outputs 0.
- LOAD: ldMcand=ldMplier=ldCount=1, p_clr=1, selX=000. Next state EVAL.
- EVAL: all strobes 0. Recode booth_win into func_sel_q and need_add:
  - 000/111: skip
  - 001/010: func 0
  - 011: func 2
  - 100: func 3
  - 101/110: func 1
- EVAL transitions (priority order):
  - count_zero=1: go to DONE
  - need_add=1: go to ADD
  - otherwise: go to SHIFT
- ADD: trP=1, trMcand=1, func_sel=func_sel_q, ldP=1, selP=000 (P <- ALU Z). Next state SHIFT.
- SHIFT: ldP=1 selP=101; ldMplier=1 selMplier=101 (also updates q_-1); ldCount=1 selCount=011. Next state EVAL.
- DONE: done=1, busy=1. Next state IDLE.
- Timing, with edge 0 sampling start in IDLE:
  - all-skip windows: done in cycle 11
  - every window adds: done in cycle 15
  - mixed windows: 11 + number of ADD visits
- start while busy (including in DONE): ignored, not queued.
- count_zero is sampled only in EVAL. If count_zero=1 already at the first EVAL (CNT_INIT=0 misuse), go straight to DONE.
- Never assert two of trP/trMcand/trMplier/trCount onto the same bus in one cycle. trMplier and trCount stay 0 in all states.

Optional Feature:
BOOTH4_EARLY_TERM_EN
- Defined: in EVAL, mplier_rest_zero=1 takes priority equal to count_zero and goes to DONE; the remaining iterations would all be skips, so the product is already final.
- Undefined: mplier_rest_zero is ignored (no logic, no lint warning); latency is fixed by Count.

Decomposition:
- Package booth4_pkg holds:
  - state enum: IDLE, LOAD, EVAL, ADD, SHIFT, DONE
  - ALU func codes: FN_ADD, FN_SUB, FN_ADD2, FN_SUB2
  - register op codes: OP_HOLD, OP_INC1, OP_INC2, OP_DEC1, OP_DEC2, OP_SHR2, OP_SHL1
- Sub-module booth4_recode: combinational, 3-bit window -> {need_add, func_sel[3:0]}.

Test Plan:
- Reset: rst=1 mid-ADD -> all outputs 0 in the same cycle; busy=0; state IDLE after release; next start accepted.
- All-skip: windows all 000, count_zero rising after the 4th SHIFT -> 4 SHIFT cycles (selP=101, selCount=011), no ADD, done=1 in cycle 11, then IDLE.
- Full recode: windows 001,011,100,110 in successive EVALs -> ADD func_sel = 0, 2, 3, 1 with trP=trMcand=ldP=1; done in cycle 15.
- Recode table: windows 000, 010, 101, 111 -> skip, func 0, func 1, skip; mirror-check booth4_recode exhaustively over all 8 codes.
- Start handling: start held high throughout a multiply -> exactly one LOAD; start high during DONE ignored; start=1 in the following IDLE cycle -> LOAD next cycle.
- With BOOTH4_EARLY_TERM_EN: skip windows, mplier_rest_zero=1 at the 2nd EVAL (cycle 4) -> DONE in cycle 5. Without the macro, the same stimulus -> done in cycle 11.
